perf_overflow_ctrl: RTL and testbench
=====================================

Name: perf_overflow_ctrl

Overview:
- Sscofpmf companion to the HPM counter block. It watches per-counter increments and values and keeps sticky per-counter overflow (OF) bits.
- Owns the mode-filter inhibit bits (MINH/SINH/UINH) of mhpmevent3..N and produces per-counter count enables back to the counter block.
- Raises the local counter-overflow interrupt (LCOFI, mip bit 13) and serves the scountovf CSR.
- Sits between the HPM counter block and csr_regfile.

Parameters:
- NumCounters, default MHPMCounterNum (6): number of HPM counters. Counter k (1..NumCounters) is hpmcounter(k+2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- debug_mode_i  in  1  core in debug mode
- priv_lvl_i  in  2  current privilege (riscv::priv_lvl_t)
- addr_i  in  12  CSR address
- we_i  in  1  CSR write strobe
- data_i  in  XLEN  CSR write data
- data_o  out  XLEN  CSR read data; owned fields only, zero elsewhere
- hit_o  out  1  addr_i is owned by this block
- cnt_inc_i  in  NumCounters  counter k increments this cycle
- cnt_we_i  in  NumCounters  software writes counter k this cycle
- cnt_val_i  in  NumCounters x 64  current counter values (q side)
- count_en_o  out  NumCounters  mode filter allows counting
- mcounteren_i  in  32  gates scountovf visibility
- lcofie_i  in  1  mie.LCOFIE
- lcofip_clr_i  in  1  csr_regfile clears mip.LCOFIP (software write 0)
- lcofip_o  out  1  pending bit for mip
- lcofi_irq_o  out  1  interrupt request = lcofip_o & lcofie_i

Behaviour:
- Reset (async, rst_ni low): all OF, MINH, SINH, UINH bits = 0; lcofip = 0. Outputs at reset: data_o = 0, hit_o = 0, count_en_o = all 1 (unless debug_mode_i), lcofip_o = 0, lcofi_irq_o = 0.
- Overflow detect: ovf[k] = cnt_inc_i[k] & !cnt_we_i[k] & (cnt_val_i[k] == 64'hFFFF_FFFF_FFFF_FFFF).
  - A software counter write in the same cycle suppresses detection.
- OF update:
  - ovf[k] sets of_q[k] on the next cycle; sticky until software writes 0.
  - Simultaneous CSR write of OF=0 and ovf[k]: set wins.
- LCOFIP:
  - Set next cycle when ovf[k] & !of_q[k] for any k. A counter whose OF is already 1 does not re-request.
  - Cleared by lcofip_clr_i; set wins over a same-cycle clear.
  - Multiple counters overflowing in one cycle: single set; all corresponding OF bits set.
- Count enable (combinational): count_en_o[k] = !debug_mode_i & !((M & minh[k]) | (S & sinh[k]) | (U & uinh[k])).
- CSR map:
  - RV64: mhpmevent(k+2) at 0x323+k-1; owned bits [63]=OF, [62]=MINH, [61]=SINH, [60]=UINH. [59:58] (VSINH/VUINH) read 0 and ignore writes.
  - RV32: the same fields sit in mhpmevent(k+2)h at 0x723+k-1, bits [31:28]; mhpmevent low addresses are not hits.
  - scountovf (0xDA0), read-only:
    - bit (k+2) = of_q[k], and in S-mode also masked by mcounteren_i[k+2]; bits 0-2 and bits above NumCounters+2 read 0.
    - Writes to 0xDA0 are ignored, hit_o = 1.
- Read path is combinational from q; a write takes effect next cycle, and a same-cycle read returns the old value.
- Addresses outside the owned set: hit_o = 0, data_o = 0, writes ignored.
- OF and LCOFIP are not frozen in debug mode. No ovf occurs there anyway because the counter block does not increment.

Decomposition:
- riscv_pkg additions:
  - CSR_SCOUNTOVF = 12'hDA0; IRQ_LCOFI = 13.
  - HPM_EVT_OF_BIT, MINH_BIT, SINH_BIT, UINH_BIT constants (RV64 positions; RV32 positions derived as bit-32).
- No sub-module: the per-counter logic is a generate loop.

Test Plan:
- Counter 1 at all-ones, cnt_inc_i[0]=1 for one cycle -> next cycle of_q[0]=1, lcofip_o=1; with lcofie_i=1, lcofi_irq_o=1; read 0x323 returns bit63=1.
- Counter 2 overflows again while OF=1 after lcofip_clr_i -> lcofip_o stays 0; OF stays 1.
- Same cycle: cnt_inc_i[2] at all-ones, write 0x325 data 0, and lcofip_clr_i -> OF=1 and lcofip_o=1 (set wins). Repeat with cnt_we_i[2]=1 -> no set.
- Write MINH on counter 1, priv=M -> count_en_o[0]=0; priv=S -> 1. debug_mode_i=1 -> all count_en_o=0.
- Counters 1 and 3 have OF=1, mcounteren_i=32'h8, priv=S, read 0xDA0 -> 32'h8; priv=M -> 32'h28.
- Assert rst_ni low mid-operation with OF bits and LCOFIP set -> all cleared immediately (async); count_en_o=all ones after release.

Source files
------------

// File: rtl/perf_overflow_ctrl_pkg.sv
// Shared constants and types for the HPM counter-overflow (Sscofpmf) controller.
// Pure declarations; no logic and no latency.
// No flow control; consumers sample these values as constants.
package perf_overflow_ctrl_pkg;

  // Privilege encoding as seen on the CSR side of the core.
  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_lvl_t;

  localparam int unsigned MHPMCounterNum = 6;

  localparam logic [11:0] CSR_SCOUNTOVF   = 12'hDA0;
  localparam logic [11:0] CSR_MHPMEVENT3  = 12'h323;
  localparam logic [11:0] CSR_MHPMEVENT3H = 12'h723;

  localparam int IRQ_LCOFI = 13;

  // Field positions inside a 64-bit mhpmevent register.
  localparam int HPM_EVT_OF_BIT = 63;
  localparam int MINH_BIT       = 62;
  localparam int SINH_BIT       = 61;
  localparam int UINH_BIT       = 60;

  // On RV32 the same fields live in the upper-half CSR, shifted down by 32.
  function automatic int evt_bit(input int pos64, input int xlen);
    return (xlen == 64) ? pos64 : pos64 - 32;
  endfunction

endpackage

// File: rtl/perf_overflow_ctrl.sv
// Sticky per-counter overflow bits, mode-filter inhibits, LCOFI pending and scountovf.
// Reads are combinational from state; writes and overflow effects land one cycle later.
// No backpressure: CSR accesses and counter events are accepted every cycle.
module perf_overflow_ctrl
  import perf_overflow_ctrl_pkg::*;
#(
  parameter int unsigned NumCounters = MHPMCounterNum,
  parameter int unsigned XLEN        = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        debug_mode_i,
  input  logic [1:0]                  priv_lvl_i,
  input  logic [11:0]                 addr_i,
  input  logic                        we_i,
  input  logic [XLEN-1:0]             data_i,
  output logic [XLEN-1:0]             data_o,
  output logic                        hit_o,
  input  logic [NumCounters-1:0]      cnt_inc_i,
  input  logic [NumCounters-1:0]      cnt_we_i,
  input  logic [NumCounters-1:0][63:0] cnt_val_i,
  output logic [NumCounters-1:0]      count_en_o,
  input  logic [31:0]                 mcounteren_i,
  input  logic                        lcofie_i,
  input  logic                        lcofip_clr_i,
  output logic                        lcofip_o,
  output logic                        lcofi_irq_o
);

  localparam int OfPos   = evt_bit(HPM_EVT_OF_BIT, XLEN);
  localparam int MinhPos = evt_bit(MINH_BIT, XLEN);
  localparam int SinhPos = evt_bit(SINH_BIT, XLEN);
  localparam int UinhPos = evt_bit(UINH_BIT, XLEN);
  // On RV32 only the upper-half event CSRs carry the owned fields.
  localparam logic [11:0] EvtBase = (XLEN == 64) ? CSR_MHPMEVENT3 : CSR_MHPMEVENT3H;

  logic [NumCounters-1:0] r_of;
  logic [NumCounters-1:0] r_minh;
  logic [NumCounters-1:0] r_sinh;
  logic [NumCounters-1:0] r_uinh;
  logic                   r_lcofip;

  logic [NumCounters-1:0] w_ovf;
  logic [NumCounters-1:0] w_evt_sel;
  logic                   w_is_m;
  logic                   w_is_s;
  logic                   w_is_u;
  logic                   w_new_req;
  logic [XLEN-1:0]        w_rdata;
  logic                   w_hit;
  logic                   w_unused;

  assign w_is_m = (priv_lvl_i == PRIV_M);
  assign w_is_s = (priv_lvl_i == PRIV_S);
  assign w_is_u = (priv_lvl_i == PRIV_U);

  for (genvar j = 0; j < NumCounters; j++) begin : g_cnt
    // A software write to the counter in the same cycle masks the wrap.
    assign w_ovf[j]      = cnt_inc_i[j] & ~cnt_we_i[j] & (&cnt_val_i[j]);
    assign w_evt_sel[j]  = (addr_i == EvtBase + 12'(j));
    assign count_en_o[j] = ~debug_mode_i &
                           ~((w_is_m & r_minh[j]) | (w_is_s & r_sinh[j]) | (w_is_u & r_uinh[j]));
  end

  // Only counters whose OF is still clear raise a fresh interrupt request.
  assign w_new_req = |(w_ovf & ~r_of);

  // Per-counter OF and inhibit state; a hardware overflow beats a software clear of OF.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_of   <= '0;
      r_minh <= '0;
      r_sinh <= '0;
      r_uinh <= '0;
    end else begin
      for (int j = 0; j < NumCounters; j++) begin
        if (we_i && w_evt_sel[j]) begin
          r_of[j]   <= data_i[OfPos] | w_ovf[j];
          r_minh[j] <= data_i[MinhPos];
          r_sinh[j] <= data_i[SinhPos];
          r_uinh[j] <= data_i[UinhPos];
        end else if (w_ovf[j]) begin
          r_of[j] <= 1'b1;
        end
      end
    end
  end

  // LCOFI pending bit; a new request beats a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lcofip <= 1'b0;
    end else begin
      r_lcofip <= w_new_req | (r_lcofip & ~lcofip_clr_i);
    end
  end

  // CSR read mux over the owned addresses; VSINH/VUINH stay zero.
  always_comb begin
    w_rdata = '0;
    w_hit   = 1'b0;
    if (addr_i == CSR_SCOUNTOVF) begin
      w_hit = 1'b1;
      for (int j = 0; j < NumCounters; j++) begin
        w_rdata[j+3] = r_of[j] & (~w_is_s | mcounteren_i[j+3]);
      end
    end
    for (int j = 0; j < NumCounters; j++) begin
      if (w_evt_sel[j]) begin
        w_hit            = 1'b1;
        w_rdata[OfPos]   = r_of[j];
        w_rdata[MinhPos] = r_minh[j];
        w_rdata[SinhPos] = r_sinh[j];
        w_rdata[UinhPos] = r_uinh[j];
      end
    end
  end

  assign data_o      = w_rdata;
  assign hit_o       = w_hit;
  assign lcofip_o    = r_lcofip;
  assign lcofi_irq_o = r_lcofip & lcofie_i;

  // Most write-data and mcounteren bits are not owned here.
  assign w_unused = ^{data_i, mcounteren_i};

endmodule

// File: tb/tb_perf_overflow_ctrl.sv
// Directed bench for perf_overflow_ctrl: overflow, LCOFIP, inhibits, scountovf, reset.
// Inputs change 2 time units after a rising edge; outputs are sampled 1 unit later.
// No backpressure on the DUT; every step is one clock.
module tb_perf_overflow_ctrl;
  import perf_overflow_ctrl_pkg::*;

  localparam int N = 6;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] OF1  = 64'h8000_0000_0000_0000;

  logic               clk;
  logic               rst_n;
  logic               debug_mode;
  logic [1:0]         priv_lvl;
  logic [11:0]        addr;
  logic               we;
  logic [63:0]        wdata;
  logic [63:0]        rdata;
  logic               hit;
  logic [N-1:0]       cnt_inc;
  logic [N-1:0]       cnt_we;
  logic [N-1:0][63:0] cnt_val;
  logic [N-1:0]       count_en;
  logic [31:0]        mcounteren;
  logic               lcofie;
  logic               lcofip_clr;
  logic               lcofip;
  logic               lcofi_irq;

  int checks;
  int errors;

  perf_overflow_ctrl #(.NumCounters(N), .XLEN(64)) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .debug_mode_i (debug_mode),
    .priv_lvl_i   (priv_lvl),
    .addr_i       (addr),
    .we_i         (we),
    .data_i       (wdata),
    .data_o       (rdata),
    .hit_o        (hit),
    .cnt_inc_i    (cnt_inc),
    .cnt_we_i     (cnt_we),
    .cnt_val_i    (cnt_val),
    .count_en_o   (count_en),
    .mcounteren_i (mcounteren),
    .lcofie_i     (lcofie),
    .lcofip_clr_i (lcofip_clr),
    .lcofip_o     (lcofip),
    .lcofi_irq_o  (lcofi_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    we         = 1'b0;
    cnt_inc    = '0;
    cnt_we     = '0;
    lcofip_clr = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    debug_mode = 1'b0;
    priv_lvl   = PRIV_M;
    addr       = 12'h000;
    wdata      = '0;
    cnt_val    = '0;
    mcounteren = '0;
    lcofie     = 1'b0;
    idle();
    #3;
    chk("rst_data", rdata, 64'h0);
    chk("rst_hit", {63'h0, hit}, 64'h0);
    chk("rst_cen", {58'h0, count_en}, 64'h3F);
    chk("rst_lcofip", {63'h0, lcofip}, 64'h0);
    chk("rst_irq", {63'h0, lcofi_irq}, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Counter 1 wraps.
    cnt_val[0] = ONES;
    cnt_inc    = 6'b000001;
    lcofie     = 1'b1;
    #1 chk("ovf1_not_yet", {63'h0, lcofip}, 64'h0);
    tick();
    idle();
    addr = 12'h323;
    #1;
    chk("ovf1_lcofip", {63'h0, lcofip}, 64'h1);
    chk("ovf1_irq", {63'h0, lcofi_irq}, 64'h1);
    chk("ovf1_hit", {63'h0, hit}, 64'h1);
    chk("ovf1_rd", rdata, OF1);
    lcofie = 1'b0;
    #1 chk("irq_masked", {63'h0, lcofi_irq}, 64'h0);
    lcofie = 1'b1;

    // Counter 2 wraps in the same cycle software clears LCOFIP: set wins.
    tick();
    cnt_val[1] = ONES;
    cnt_inc    = 6'b000010;
    lcofip_clr = 1'b1;
    tick();
    idle();
    addr = 12'h324;
    #1;
    chk("clr_vs_set", {63'h0, lcofip}, 64'h1);
    chk("ovf2_rd", rdata, OF1);
    lcofip_clr = 1'b1;
    tick();
    idle();
    #1 chk("clr", {63'h0, lcofip}, 64'h0);
    // Counter 2 wraps again with OF already set: no new request.
    cnt_inc = 6'b000010;
    tick();
    idle();
    #1;
    chk("rewrap_lcofip", {63'h0, lcofip}, 64'h0);
    chk("rewrap_of", rdata, OF1);

    // Counter 3: wrap, OF=0 write and LCOFIP clear all together.
    cnt_val[2] = ONES;
    cnt_inc    = 6'b000100;
    we         = 1'b1;
    addr       = 12'h325;
    wdata      = 64'h0;
    lcofip_clr = 1'b1;
    tick();
    idle();
    #1;
    chk("c3_of_set", rdata, OF1);
    chk("c3_lcofip", {63'h0, lcofip}, 64'h1);
    we         = 1'b1;
    wdata      = 64'h0;
    lcofip_clr = 1'b1;
    #1 chk("rd_old", rdata, OF1);
    tick();
    idle();
    #1;
    chk("c3_cleared", rdata, 64'h0);
    chk("c3_lcofip_clr", {63'h0, lcofip}, 64'h0);
    // Software counter write masks the wrap.
    cnt_inc = 6'b000100;
    cnt_we  = 6'b000100;
    tick();
    idle();
    #1;
    chk("cwe_of", rdata, 64'h0);
    chk("cwe_lcofip", {63'h0, lcofip}, 64'h0);

    // MINH on counter 1, keep OF; VSINH bit must be dropped.
    addr  = 12'h323;
    we    = 1'b1;
    wdata = 64'hC800_0000_0000_0000;
    tick();
    idle();
    #1;
    chk("evt1_rd", rdata, 64'hC000_0000_0000_0000);
    chk("cen_m", {58'h0, count_en}, 64'h3E);
    priv_lvl = PRIV_S;
    #1 chk("cen_s", {58'h0, count_en}, 64'h3F);
    priv_lvl = PRIV_U;
    #1 chk("cen_u", {58'h0, count_en}, 64'h3F);
    priv_lvl   = PRIV_M;
    debug_mode = 1'b1;
    #1 chk("cen_dbg", {58'h0, count_en}, 64'h0);
    debug_mode = 1'b0;

    // Leave OF set on counters 1 and 3 only.
    tick();
    addr  = 12'h324;
    we    = 1'b1;
    wdata = 64'h0;
    tick();
    addr  = 12'h325;
    wdata = OF1;
    tick();
    idle();
    addr       = 12'hDA0;
    mcounteren = 32'h8;
    priv_lvl   = PRIV_S;
    #1;
    chk("sovf_s", rdata, 64'h8);
    chk("sovf_hit", {63'h0, hit}, 64'h1);
    priv_lvl = PRIV_M;
    #1 chk("sovf_m", rdata, 64'h28);
    we    = 1'b1;
    wdata = ONES;
    tick();
    idle();
    #1 chk("sovf_ro", rdata, 64'h28);
    addr = 12'h323;
    #1 chk("sovf_wr_no_side", rdata, 64'hC000_0000_0000_0000);
    addr = 12'h329;
    #1;
    chk("oob_hi_hit", {63'h0, hit}, 64'h0);
    chk("oob_hi_data", rdata, 64'h0);
    addr = 12'h322;
    #1 chk("oob_lo_hit", {63'h0, hit}, 64'h0);
    addr = 12'h023;
    #1 chk("rv32_lo_nohit", {63'h0, hit}, 64'h0);

    // Counter 4 wraps, then async reset mid-cycle.
    tick();
    cnt_val[3] = ONES;
    cnt_inc    = 6'b001000;
    tick();
    idle();
    #1 chk("c4_lcofip", {63'h0, lcofip}, 64'h1);
    addr = 12'hDA0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_lcofip", {63'h0, lcofip}, 64'h0);
    chk("arst_sovf", rdata, 64'h0);
    chk("arst_cen", {58'h0, count_en}, 64'h3F);
    tick();
    rst_n = 1'b1;
    addr  = 12'h323;
    tick();
    #1;
    chk("post_rst_evt", rdata, 64'h0);
    chk("post_rst_cen", {58'h0, count_en}, 64'h3F);
    chk("post_rst_irq", {63'h0, lcofi_irq}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
